// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: accepts op/a/b over valid/ready, runs PASS, AND,
// SHL (one bit per cycle) or INC, then holds result and flags until taken.
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready, op, a, b        -- request side
//        out_valid/out_ready, result, carry -- response side
//        zero, illegal, busy                -- status
module alu_seq_ctrl #(
    parameter int WIDTH = 20,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [15:0]        op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               illegal_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [CW-1:0]      n_sat_d;
    logic [WIDTH-1:0]   res_d;
    logic               cy_d;
    logic               ill_d;
    logic               last_d;

    // Shift count clamps at WIDTH; anything longer shifts everything out.
    always_comb begin
        n_sat_d = CW'(b[SHW-1:0]);
        if (int'(b[SHW-1:0]) > WIDTH) begin
            n_sat_d = CW'(WIDTH);
        end
    end

    // One EXEC step. a_q is the working register for SHL.
    always_comb begin
        res_d  = '0;
        cy_d   = 1'b0;
        ill_d  = 1'b0;
        last_d = 1'b1;
        unique case (1'b1)
            op_q[0]: res_d = a_q;
            op_q[1]: res_d = a_q & b_q;
            op_q[2]: begin
                res_d = a_q;
                if (cnt_q != '0) begin
                    res_d = {a_q[WIDTH-2:0], 1'b0};
                    cy_d  = a_q[WIDTH-1];
                end
                // n = 0 still takes a single no-op step
                last_d = (cnt_q <= CW'(1));
            end
            op_q[3]: {cy_d, res_d} = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= 16'(1) << op;
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= n_sat_d;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q[2]) begin
                        a_q <= res_d;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    if (last_d) begin
                        result_q    <= res_d;
                        carry_q     <= cy_d;
                        zero_q      <= (res_d == '0);
                        illegal_q   <= ill_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: driver pushes model predictions,
// monitor pops and compares when out_valid rises.
module tb_alu_seq_ctrl;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         illegal;
    logic         busy;

    alu_seq_ctrl #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         z;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_or = 0;
    bit   rand_or = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (hold_or) out_ready = 1'b0;
        else if (rand_or) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the opcode rules.
    function automatic exp_t model(input logic [3:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t   e;
        int     n;
        longint t;
        e.res = '0; e.cy = 0; e.ill = 0; e.lat = 1; e.acc = 0;
        case (o)
            4'd0: e.res = x;
            4'd1: e.res = x & y;
            4'd2: begin
                n = int'(y[4:0]);
                if (n > W) n = W;
                t = longint'(x) << n;
                e.res = t[W-1:0];
                e.cy  = (n == 0) ? 1'b0 : t[W];
                e.lat = (n == 0) ? 1 : n;
            end
            4'd3: begin
                e.res = x + 1;
                e.cy  = (x == {W{1'b1}});
            end
            default: e.ill = 1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic send(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        while (!in_ready) begin
            k++;
            if (k > 200) begin
                chk("in_ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        e = model(o, x, y);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 4'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    bit           prev_v = 0;
    bit           prev_hs = 0;
    logic [W-1:0] h_res;
    logic [2:0]   h_fl;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v  = 0;
            prev_hs = 0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("carry", 32'(carry), 32'(e.cy));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("latency", cyc - e.acc, e.lat);
                end
                h_res = result;
                h_fl  = {carry, zero, illegal};
            end else if (out_valid) begin
                chk("hold_result", 32'(result), 32'(h_res));
                chk("hold_flags", 32'({carry, zero, illegal}), 32'(h_fl));
            end
            if (out_valid) chk("in_ready_done", 32'(in_ready), 0);
            if (prev_hs) chk("in_ready_back", 32'(in_ready), 1);
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    initial begin
        int k;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({carry, zero, illegal}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        send(4'd1, 20'hF0F0F, 20'h0FF00);
        send(4'd3, 20'hFFFFF, 20'h00000);
        send(4'd3, 20'h0000F, 20'h00000);
        send(4'd2, 20'h80001, 20'd1);
        send(4'd2, 20'h00001, 20'd3);
        send(4'd2, 20'hFFFFF, 20'd31);
        send(4'd2, 20'hABCDE, 20'd0);
        send(4'd2, 20'h12345, 20'd20);
        drain();

        // Hold the consumer off and wiggle inputs; outputs must not move.
        hold_or = 1;
        send(4'd9, 20'h55555, 20'h0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("illegal_valid", 32'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            op = 4'($urandom);
            #1;
            chk("done_in_ready", 32'(in_ready), 0);
            chk("done_busy", 32'(busy), 1);
        end
        in_valid = 1'b0;
        hold_or = 0;
        drain();

        // Reset during a long shift drops the transaction.
        send(4'd2, 20'hFFFFF, 20'd20);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(4'd0, 20'h12345, 20'h0);
        drain();

        rand_or = 1;
        repeat (150) begin
            logic [3:0] o;
            o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3))
                                           : 4'($urandom);
            send(o, W'($urandom), W'($urandom));
        end
        drain();
        rand_or = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
